// File: rtl/safe_lock_pkg.sv
// rtl/safe_lock_pkg.sv - status and tx state encodings shared by lock-side RTL and benches
package safe_lock_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK    = 2'b00,
        ST_REJECT    = 2'b01,
        ST_TIMEOUT   = 2'b10,
        ST_PROTO_ERR = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SEND    = 3'd1,
        TX_GAP     = 3'd2,
        TX_WAIT    = 3'd3,
        TX_RESP    = 3'd4,
        TX_LOCKOUT = 3'd5
    } tx_state_e;

endpackage

// File: rtl/safe_code_tx.sv
// rtl/safe_code_tx.sv - serialises a code toward the lock, reports its verdict, enforces lockout
module safe_code_tx
    import safe_lock_pkg::*;
#(
    parameter int CODE_W      = 4,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT     = 15,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_code,
    output logic              ser_valid,
    output logic              ser_data,
    input  logic              lock_valid,
    input  logic              lock_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic              locked_out
);

    localparam int CNT_MAX = (GAP_CYC > TIMEOUT)
                           ? ((GAP_CYC > LOCKOUT_CYC) ? GAP_CYC : LOCKOUT_CYC)
                           : ((TIMEOUT > LOCKOUT_CYC) ? TIMEOUT : LOCKOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'((LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0);
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(CODE_W - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);

    tx_state_e          state;
    status_e            status;
    logic [CODE_W-1:0]  shreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [FAIL_W-1:0]  fail_cnt;
    logic               ready_en;

    logic    listening;
    logic    take_verdict;
    status_e verdict_st;

    // A verdict counts only while a code is in flight (SEND, GAP or WAIT).
    assign listening    = (state == TX_SEND) || (state == TX_GAP) || (state == TX_WAIT);
    assign take_verdict = listening && (lock_valid || lock_out);
    assign verdict_st   = (lock_valid && lock_out) ? ST_PROTO_ERR :
                          lock_out                 ? ST_UNLOCK    : ST_REJECT;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= TX_IDLE;
            status   <= ST_UNLOCK;
            shreg    <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
            fail_cnt <= '0;
            ready_en <= 1'b0;
        end else begin
            // Holds req_ready low in the reset cycle itself; opens on the first edge after release.
            ready_en <= 1'b1;
            if (take_verdict) begin
                status <= verdict_st;
                state  <= TX_RESP;
                if (verdict_st == ST_REJECT) begin
                    if (fail_cnt != FAIL_MAX)
                        fail_cnt <= fail_cnt + 1'b1;
                end else if (verdict_st == ST_UNLOCK) begin
                    fail_cnt <= '0;
                end
            end else begin
                case (state)
                    TX_IDLE: begin
                        if (req_valid && ready_en) begin
                            shreg   <= req_code;
                            bit_cnt <= BIT_LOAD;
                            state   <= TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (bit_cnt == '0) begin
                            cnt   <= WAIT_LOAD;
                            state <= TX_WAIT;
                        end else begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                            if (GAP_CYC > 0) begin
                                cnt   <= GAP_LOAD;
                                state <= TX_GAP;
                            end
                        end
                    end
                    TX_GAP: begin
                        if (cnt == '0)
                            state <= TX_SEND;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    TX_WAIT: begin
                        if (cnt == '0) begin
                            status <= ST_TIMEOUT;
                            state  <= TX_RESP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    TX_RESP: begin
                        if (rsp_ready) begin
                            if (fail_cnt == FAIL_MAX) begin
                                cnt   <= LOCK_LOAD;
                                state <= TX_LOCKOUT;
                            end else begin
                                state <= TX_IDLE;
                            end
                        end
                    end
                    TX_LOCKOUT: begin
                        if (cnt == '0) begin
                            fail_cnt <= '0;
                            state    <= TX_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

    assign req_ready  = (state == TX_IDLE) && ready_en;
    assign ser_valid  = (state == TX_SEND);
    assign ser_data   = (state == TX_SEND) && shreg[CODE_W-1];
    assign rsp_valid  = (state == TX_RESP);
    assign rsp_status = status;
    assign locked_out = (state == TX_LOCKOUT);

endmodule

// File: tb/tb_safe_code_tx.sv
// tb/tb_safe_code_tx.sv - directed vector bench for safe_code_tx
module tb_safe_code_tx;

    logic       clk;
    logic       rstn;

    logic       req_valid, req_ready, ser_valid, ser_data;
    logic [3:0] req_code;
    logic       lock_valid, lock_out, rsp_valid, rsp_ready, locked_out;
    logic [1:0] rsp_status;

    logic       req_valid_g, req_ready_g, ser_valid_g, ser_data_g;
    logic [3:0] req_code_g;
    logic       lock_valid_g, lock_out_g, rsp_valid_g, rsp_ready_g, locked_out_g;
    logic [1:0] rsp_status_g;

    int n_chk = 0;
    int n_err = 0;

    safe_code_tx dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
        .ser_valid(ser_valid), .ser_data(ser_data),
        .lock_valid(lock_valid), .lock_out(lock_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .locked_out(locked_out)
    );

    safe_code_tx #(.GAP_CYC(2)) dut_g (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_g), .req_ready(req_ready_g), .req_code(req_code_g),
        .ser_valid(ser_valid_g), .ser_data(ser_data_g),
        .lock_valid(lock_valid_g), .lock_out(lock_out_g),
        .rsp_valid(rsp_valid_g), .rsp_ready(rsp_ready_g), .rsp_status(rsp_status_g),
        .locked_out(locked_out_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        int         vbit;   // bit number (1..4) carrying the verdict, 0 = lock silent
        logic       lv;
        logic       lo;
        logic [1:0] st;
        int         hold;   // cycles rsp_ready stays low while rsp_valid is up
        bit         lock;   // lockout expected after the handshake
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [3:0] code, input int vbit, input logic lv,
                                input logic lo, input logic [1:0] st, input int hold,
                                input bit lock);
        vec_t v;
        v.code = code; v.vbit = vbit; v.lv = lv; v.lo = lo;
        v.st = st; v.hold = hold; v.lock = lock;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_tx(input int idx, input vec_t v);
        int nb;
        int lk;
        bit rdy_low;
        nb = (v.vbit == 0) ? 4 : v.vbit;
        @(negedge clk);
        chk($sformatf("v%0d req_ready idle", idx), int'(req_ready), 1);
        req_valid = 1'b1;
        req_code  = v.code;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= nb; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d bit%0d valid", idx, i), int'(ser_valid), 1);
            chk($sformatf("v%0d bit%0d data", idx, i), int'(ser_data), int'(v.code[4-i]));
            if (i == v.vbit) begin
                lock_valid = v.lv;
                lock_out   = v.lo;
            end
        end
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        lock_out   = 1'b0;
        if (v.vbit == 0) begin
            for (int w = 0; w < 15; w++) begin
                @(negedge clk);
                chk($sformatf("v%0d wait%0d ser_valid", idx, w), int'(ser_valid), 0);
                chk($sformatf("v%0d wait%0d rsp_valid", idx, w), int'(rsp_valid), 0);
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", idx), int'(rsp_valid), 1);
        chk($sformatf("v%0d rsp_status", idx), int'(rsp_status), int'(v.st));
        chk($sformatf("v%0d ser_valid in resp", idx), int'(ser_valid), 0);
        chk($sformatf("v%0d req_ready in resp", idx), int'(req_ready), 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold%0d rsp_valid", idx, h), int'(rsp_valid), 1);
            chk($sformatf("v%0d hold%0d rsp_status", idx, h), int'(rsp_status), int'(v.st));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (v.lock) begin
            lk = 0;
            rdy_low = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (!locked_out) break;
                lk++;
                if (req_ready) rdy_low = 1'b0;
            end
            chk($sformatf("v%0d lockout length", idx), lk, 64);
            chk($sformatf("v%0d req_ready low in lockout", idx), int'(rdy_low), 1);
            chk($sformatf("v%0d req_ready after lockout", idx), int'(req_ready), 1);
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d no lockout", idx), int'(locked_out), 0);
            chk($sformatf("v%0d back to idle", idx), int'(req_ready), 1);
        end
    endtask

    initial begin
        logic [9:0] exp_v;
        logic [9:0] exp_d;

        rstn = 1'b0;
        req_valid = 1'b0; req_code = '0; lock_valid = 1'b0; lock_out = 1'b0; rsp_ready = 1'b0;
        req_valid_g = 1'b0; req_code_g = '0; lock_valid_g = 1'b0; lock_out_g = 1'b0; rsp_ready_g = 1'b0;

        vecs[0]  = mk(4'b1011, 4, 1'b0, 1'b1, 2'b00, 0, 1'b0);
        vecs[1]  = mk(4'b0011, 1, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[2]  = mk(4'b0110, 2, 1'b1, 1'b1, 2'b11, 0, 1'b0);
        vecs[3]  = mk(4'b1100, 0, 1'b0, 1'b0, 2'b10, 5, 1'b0);
        vecs[4]  = mk(4'b0101, 2, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[5]  = mk(4'b1001, 3, 1'b0, 1'b1, 2'b00, 0, 1'b0);
        vecs[6]  = mk(4'b1110, 1, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[7]  = mk(4'b0111, 4, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[8]  = mk(4'b1000, 1, 1'b1, 1'b1, 2'b11, 0, 1'b0);
        vecs[9]  = mk(4'b0001, 3, 1'b1, 1'b0, 2'b01, 0, 1'b1);
        vecs[10] = mk(4'b1010, 2, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[11] = mk(4'b0010, 1, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[12] = mk(4'b1111, 1, 1'b0, 1'b1, 2'b00, 0, 1'b0);
        vecs[13] = mk(4'b1101, 4, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        vecs[14] = mk(4'b0100, 3, 1'b1, 1'b0, 2'b01, 0, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset ser_valid", int'(ser_valid), 0);
        chk("reset ser_data", int'(ser_data), 0);
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_status", int'(rsp_status), 0);
        chk("reset locked_out", int'(locked_out), 0);
        chk("reset req_ready", int'(req_ready), 0);
        rstn = 1'b1;
        #1 chk("req_ready before first edge", int'(req_ready), 0);
        @(posedge clk);
        #1 chk("req_ready first edge", int'(req_ready), 1);

        for (int k = 0; k < 15; k++) run_tx(k, vecs[k]);

        // Two-cycle gaps between bits of 1011, verdict on the last bit.
        exp_v = 10'b1001001001;
        exp_d = 10'b1000001001;
        @(negedge clk);
        chk("gap req_ready", int'(req_ready_g), 1);
        req_valid_g = 1'b1;
        req_code_g  = 4'b1011;
        @(posedge clk);
        #1 req_valid_g = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("gap cyc%0d ser_valid", c), int'(ser_valid_g), int'(exp_v[10-c]));
            chk($sformatf("gap cyc%0d ser_data", c), int'(ser_data_g), int'(exp_d[10-c]));
            if (c == 10) lock_out_g = 1'b1;
        end
        @(posedge clk);
        #1 lock_out_g = 1'b0;
        @(negedge clk);
        chk("gap rsp_valid", int'(rsp_valid_g), 1);
        chk("gap rsp_status", int'(rsp_status_g), 0);
        rsp_ready_g = 1'b1;
        @(posedge clk);
        #1 rsp_ready_g = 1'b0;
        @(negedge clk);
        chk("gap back to idle", int'(req_ready_g), 1);

        // Reset in the middle of the third bit; reject count (2 before) must be cleared.
        @(negedge clk);
        req_valid = 1'b1;
        req_code  = 4'b1011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midcode bit3 valid", int'(ser_valid), 1);
        #2 rstn = 1'b0;
        #1;
        chk("midcode reset ser_valid", int'(ser_valid), 0);
        chk("midcode reset ser_data", int'(ser_data), 0);
        chk("midcode reset req_ready", int'(req_ready), 0);
        chk("midcode reset rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("midcode req_ready after release", int'(req_ready), 1);
        run_tx(100, mk(4'b1011, 4, 1'b1, 1'b0, 2'b01, 0, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
